spmv_mem_arbiter: RTL and testbench
===================================

Name: spmv_mem_arbiter

Overview:
- Shares one memory request/response port among NUM_PE spmv_pe instances.
- Each PE's registered request stream lands in a per-PE skid FIFO. A round-robin scheduler drains the FIFOs into one registered memory request.
- Load tags are widened with the PE index. Responses are routed back to the owning PE on the returned tag.
- Sits between the PE array and the memory-controller interface.

Parameters:
NUM_PE, 4, number of PEs sharing the port (power of two, 2..16)
PE_BITS, 2, log2(NUM_PE)
FIFO_DEPTH, 8, per-PE request skid FIFO entries (power of two)
SKID, 3, entries kept free when pe_req_stall asserts; covers the PE's stall-to-request latency

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pe_req_ld  in  NUM_PE  per-PE load request
pe_req_st  in  NUM_PE  per-PE store request
pe_req_addr  in  48*NUM_PE  per-PE byte address, PE i at [48i+47:48i]
pe_req_d_or_tag  in  64*NUM_PE  store data, or load tag in bits [2:0]
pe_req_stall  out  NUM_PE  per-PE backpressure, registered
pe_rsp_push  out  NUM_PE  one-hot response valid
pe_rsp_tag  out  3  response tag (original PE tag)
pe_rsp_q  out  64  response data (broadcast)
pe_rsp_stall  in  NUM_PE  per-PE response backpressure
mem_req_ld  out  1  load request to memory
mem_req_st  out  1  store request to memory
mem_req_addr  out  48  address
mem_req_d_or_tag  out  64  store data, or {PE index, 3-bit tag} in bits [PE_BITS+2:0]
mem_req_stall  in  1  memory backpressure
mem_rsp_push  in  1  response valid
mem_rsp_tag  in  PE_BITS+3  response tag
mem_rsp_q  in  64  response data
mem_rsp_stall  out  1  response backpressure to memory, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0.
  - FIFOs are emptied and the round-robin pointer goes to 0.
  - Reset mid-operation drops queued requests silently.
- Capture:
  - A cycle with pe_req_ld[i] or pe_req_st[i] writes {st, addr, d_or_tag} into FIFO i.
  - ld and st both set in one cycle: treat as a store and set the sticky error flag err_q (internal, simulation-visible).
  - A write when FIFO i is full is dropped and sets err_q. The bench checks that err_q never sets.
- Backpressure: pe_req_stall[i] is registered and equals (count_i >= FIFO_DEPTH-SKID).
- Arbitration, one grant per cycle:
  - Grant is allowed only when mem_req_stall is low.
  - Eligible requesters are the non-empty FIFOs.
  - The winner is the first eligible index at or after rr_ptr, searching upward with wrap.
  - After a grant, rr_ptr becomes winner+1 mod NUM_PE.
  - No grant leaves rr_ptr unchanged.
  - A granted FIFO pops in the same cycle.
- Request output, registered, one cycle after grant:
  - mem_req_ld/st reflect the popped entry.
  - Loads: mem_req_d_or_tag = {zeros, winner, tag[2:0]}.
  - Stores: mem_req_d_or_tag passes the 64-bit data unchanged.
  - Cycles with no grant drive ld=st=0; addr and data are don't-care but held.
- Request latency: PE request to mem_req is 2 cycles minimum with an empty FIFO and a free port (capture cycle, then grant/register cycle).
- Simultaneous events: capture and pop on the same FIFO in one cycle keeps the count unchanged. Full plus simultaneous pop accepts the write.
- Response path, registered, 1-cycle latency:
  - pe_rsp_push[mem_rsp_tag[PE_BITS+2:3]] = mem_rsp_push; all other bits 0.
  - pe_rsp_tag = mem_rsp_tag[2:0].
  - pe_rsp_q = mem_rsp_q.
- Response backpressure: mem_rsp_stall is registered and equals |pe_rsp_stall. The conservative OR is intentional; PEs absorb 2 cycles of in-flight responses.
- Ordering: per-PE request order is preserved. No ordering is guaranteed between PEs.

Decomposition:
- Shared package spmv_mem_pkg:
  - REQ_ENTRY_W = 1+48+64.
  - ADDR_W=48, DATA_W=64, PE_TAG_W=3.
  - Function rr_pick(eligible, ptr) returning the winner index.
- One sub-module: spmv_req_skid_fifo. It is a registered-count FIFO with async active-low reset and an almost-full threshold, instantiated NUM_PE times.
- The arbiter, output register and response router stay in the top module.

Test Plan:
- Single PE load: PE1 ld addr 0x1000 tag 5 -> 2 cycles later mem_req_ld=1, addr 0x1000, d_or_tag[4:0]=0b01101. Response tag 0b01101, data 0xABCD -> next cycle pe_rsp_push=0b0010, pe_rsp_tag=5, pe_rsp_q=0xABCD.
- Fairness: all 4 PEs issue one store per cycle for 20 cycles with mem_req_stall=0 -> grants rotate 0,1,2,3,0... Each PE gets 5 grants per 20 cycles. Store data is unaltered.
- Memory stall: hold mem_req_stall=1 for 10 cycles while PE0 streams loads -> pe_req_stall[0] rises when count reaches 5. No entry is dropped (err_q=0). After release, all 8 requests appear in order.
- Response backpressure: pe_rsp_stall[2]=1 -> mem_rsp_stall=1 on the next cycle. Clearing it drops mem_rsp_stall 1 cycle later.
- Simultaneous capture/pop at full: FIFO3 full with a grant to 3 and a new PE3 request in the same cycle -> count stays 8, err_q=0, order preserved.
- Async reset mid-burst: assert rst_n=0 between clock edges during traffic -> all outputs 0 immediately. After release, the first grant goes to PE0.

Source files
------------

// File: rtl/spmv_mem_pkg.sv
// Shared widths and the round-robin pick helper for the SpMV memory arbiter.
package spmv_mem_pkg;

  localparam int unsigned ADDR_W      = 48;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned PE_TAG_W    = 3;
  localparam int unsigned REQ_ENTRY_W = 1 + ADDR_W + DATA_W;

  // First set bit of eligible at or after ptr, wrapping within num entries.
  function automatic logic [3:0] rr_pick(input logic [15:0] eligible, input logic [3:0] ptr,
                                         input int unsigned num);
    logic [3:0] result;
    logic [3:0] idx;
    logic       found;
    result = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      idx = 4'((32'(ptr) + i) % num);
      if (i < num && !found && eligible[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/spmv_req_skid_fifo.sv
// Per-PE request FIFO with a registered occupancy count and a registered almost-full flag.
module spmv_req_skid_fifo #(
  parameter int unsigned WIDTH    = 113,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_afull
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_afull;
  logic             w_wr_en;
  logic             w_rd_en;
  logic [CNT_W-1:0] w_count_d;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_afull = r_afull;
  assign o_data  = r_mem[r_rptr];

  // A full FIFO still accepts a write when it pops in the same cycle.
  assign w_wr_en   = i_push && (!o_full || i_pop);
  assign w_rd_en   = i_pop && !o_empty;
  assign w_count_d = r_count + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_en) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_d;
      r_afull <= (w_count_d >= CNT_W'(AFULL_TH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/spmv_mem_arbiter.sv
// Round-robin sharing of one memory request/response port among NUM_PE SpMV PEs.
module spmv_mem_arbiter
  import spmv_mem_pkg::*;
#(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned PE_BITS    = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SKID       = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PE-1:0]          pe_req_ld,
  input  logic [NUM_PE-1:0]          pe_req_st,
  input  logic [ADDR_W*NUM_PE-1:0]   pe_req_addr,
  input  logic [DATA_W*NUM_PE-1:0]   pe_req_d_or_tag,
  output logic [NUM_PE-1:0]          pe_req_stall,
  output logic [NUM_PE-1:0]          pe_rsp_push,
  output logic [PE_TAG_W-1:0]        pe_rsp_tag,
  output logic [DATA_W-1:0]          pe_rsp_q,
  input  logic [NUM_PE-1:0]          pe_rsp_stall,
  output logic                       mem_req_ld,
  output logic                       mem_req_st,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_d_or_tag,
  input  logic                       mem_req_stall,
  input  logic                       mem_rsp_push,
  input  logic [PE_BITS+PE_TAG_W-1:0] mem_rsp_tag,
  input  logic [DATA_W-1:0]          mem_rsp_q,
  output logic                       mem_rsp_stall
);

  logic [NUM_PE-1:0]      w_push;
  logic [NUM_PE-1:0]      w_pop;
  logic [NUM_PE-1:0]      w_empty;
  logic [NUM_PE-1:0]      w_full;
  logic [NUM_PE-1:0]      w_afull;
  logic [NUM_PE-1:0]      w_rsp_sel;
  logic [REQ_ENTRY_W-1:0] w_rd_data [NUM_PE];
  logic [NUM_PE-1:0]      w_elig;
  logic                   w_grant;
  logic [3:0]             w_pick;
  logic [3:0]             w_unused_pick;
  logic [PE_BITS-1:0]     w_winner;
  logic [REQ_ENTRY_W-1:0] w_win_entry;
  logic                   w_win_st;
  logic                   w_err_set;

  logic                   r_mem_ld;
  logic                   r_mem_st;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [DATA_W-1:0]      r_mem_data;
  logic [PE_BITS-1:0]     r_rr_ptr;
  logic [NUM_PE-1:0]      r_rsp_push;
  logic [PE_TAG_W-1:0]    r_rsp_tag;
  logic [DATA_W-1:0]      r_rsp_q;
  logic                   r_mem_rsp_stall;
  logic                   err_q;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    assign w_push[g]    = pe_req_ld[g] | pe_req_st[g];
    assign w_pop[g]     = w_grant && (w_winner == PE_BITS'(g));
    assign w_rsp_sel[g] = mem_rsp_push && (mem_rsp_tag[PE_BITS+PE_TAG_W-1:PE_TAG_W] == PE_BITS'(g));

    // ld+st together is captured as a store (st bit wins).
    spmv_req_skid_fifo #(
      .WIDTH    (REQ_ENTRY_W),
      .DEPTH    (FIFO_DEPTH),
      .AFULL_TH (FIFO_DEPTH - SKID)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_data  ({pe_req_st[g], pe_req_addr[ADDR_W*g +: ADDR_W], pe_req_d_or_tag[DATA_W*g +: DATA_W]}),
      .i_pop   (w_pop[g]),
      .o_data  (w_rd_data[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_afull (w_afull[g])
    );
  end

  assign w_elig        = ~w_empty;
  assign w_grant       = !mem_req_stall && (|w_elig);
  assign w_pick        = rr_pick(16'(w_elig), 4'(r_rr_ptr), NUM_PE);
  assign w_unused_pick = w_pick;
  assign w_winner      = w_pick[PE_BITS-1:0];
  assign w_win_entry   = w_rd_data[w_winner];
  assign w_win_st      = w_win_entry[REQ_ENTRY_W-1];
  assign w_err_set     = (|(pe_req_ld & pe_req_st)) | (|(w_push & w_full & ~w_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_ld        <= 1'b0;
      r_mem_st        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_data      <= '0;
      r_rr_ptr        <= '0;
      r_rsp_push      <= '0;
      r_rsp_tag       <= '0;
      r_rsp_q         <= '0;
      r_mem_rsp_stall <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      r_mem_ld <= w_grant && !w_win_st;
      r_mem_st <= w_grant && w_win_st;
      if (w_grant) begin
        r_mem_addr <= w_win_entry[DATA_W +: ADDR_W];
        // Loads carry the owning PE index above the PE's own tag.
        r_mem_data <= w_win_st ? w_win_entry[DATA_W-1:0]
                               : DATA_W'({w_winner, w_win_entry[PE_TAG_W-1:0]});
        r_rr_ptr   <= w_winner + PE_BITS'(1);
      end
      r_rsp_push      <= w_rsp_sel;
      r_rsp_tag       <= mem_rsp_tag[PE_TAG_W-1:0];
      r_rsp_q         <= mem_rsp_q;
      r_mem_rsp_stall <= |pe_rsp_stall;
      err_q           <= err_q | w_err_set;
    end
  end

  assign pe_req_stall     = w_afull;
  assign pe_rsp_push      = r_rsp_push;
  assign pe_rsp_tag       = r_rsp_tag;
  assign pe_rsp_q         = r_rsp_q;
  assign mem_req_ld       = r_mem_ld;
  assign mem_req_st       = r_mem_st;
  assign mem_req_addr     = r_mem_addr;
  assign mem_req_d_or_tag = r_mem_data;
  assign mem_rsp_stall    = r_mem_rsp_stall;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Randomized and directed bench for spmv_mem_arbiter against a queue-based reference model.
module tb_spmv_mem_arbiter;

  localparam int NP = 4;
  localparam int DEPTH = 8;
  localparam int THR = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    pe_req_ld, pe_req_st, pe_req_stall, pe_rsp_push, pe_rsp_stall;
  logic [191:0]  pe_req_addr;
  logic [255:0]  pe_req_d_or_tag;
  logic [2:0]    pe_rsp_tag;
  logic [63:0]   pe_rsp_q, mem_req_d_or_tag, mem_rsp_q;
  logic          mem_req_ld, mem_req_st, mem_req_stall, mem_rsp_push, mem_rsp_stall;
  logic [47:0]   mem_req_addr;
  logic [4:0]    mem_rsp_tag;

  spmv_mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pe_req_ld        (pe_req_ld),
    .pe_req_st        (pe_req_st),
    .pe_req_addr      (pe_req_addr),
    .pe_req_d_or_tag  (pe_req_d_or_tag),
    .pe_req_stall     (pe_req_stall),
    .pe_rsp_push      (pe_rsp_push),
    .pe_rsp_tag       (pe_rsp_tag),
    .pe_rsp_q         (pe_rsp_q),
    .pe_rsp_stall     (pe_rsp_stall),
    .mem_req_ld       (mem_req_ld),
    .mem_req_st       (mem_req_st),
    .mem_req_addr     (mem_req_addr),
    .mem_req_d_or_tag (mem_req_d_or_tag),
    .mem_req_stall    (mem_req_stall),
    .mem_rsp_push     (mem_rsp_push),
    .mem_rsp_tag      (mem_rsp_tag),
    .mem_rsp_q        (mem_rsp_q),
    .mem_rsp_stall    (mem_rsp_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic [47:0] addr;
    logic [63:0] data;
  } ent_t;

  ent_t        m_q[NP][$];
  int          m_ptr;
  logic        exp_ld, exp_st, exp_mrs, exp_err;
  logic [47:0] exp_addr;
  logic [63:0] exp_data, exp_rsp_q;
  logic [3:0]  exp_stall, exp_rsp_push;
  logic [2:0]  exp_rsp_tag;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_q[i].delete();
    m_ptr = 0;
    {exp_ld, exp_st, exp_mrs, exp_err} = '0;
    exp_addr = '0; exp_data = '0; exp_rsp_q = '0;
    exp_stall = '0; exp_rsp_push = '0; exp_rsp_tag = '0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit   gnt = 0;
    int   win = 0;
    ent_t e;
    if (!mem_req_stall) begin
      for (int k = 0; k < NP; k++) begin
        if (!gnt && m_q[(m_ptr + k) % NP].size() > 0) begin
          gnt = 1;
          win = (m_ptr + k) % NP;
        end
      end
    end
    exp_ld = 0;
    exp_st = 0;
    if (gnt) begin
      e = m_q[win].pop_front();
      exp_ld = !e.st;
      exp_st = e.st;
      exp_addr = e.addr;
      exp_data = e.st ? e.data : 64'(win * 8 + int'(e.data[2:0]));
      m_ptr = (win + 1) % NP;
    end
    for (int i = 0; i < NP; i++) begin
      if (pe_req_ld[i] || pe_req_st[i]) begin
        if (pe_req_ld[i] && pe_req_st[i]) exp_err = 1;
        e.st = pe_req_st[i];
        e.addr = pe_req_addr[48*i +: 48];
        e.data = pe_req_d_or_tag[64*i +: 64];
        if (m_q[i].size() >= DEPTH) exp_err = 1;
        else m_q[i].push_back(e);
      end
      exp_stall[i] = (m_q[i].size() >= THR);
    end
    exp_rsp_push = mem_rsp_push ? (4'b0001 << mem_rsp_tag[4:3]) : 4'b0000;
    exp_rsp_tag = mem_rsp_tag[2:0];
    exp_rsp_q = mem_rsp_q;
    exp_mrs = |pe_rsp_stall;
  endtask

  task automatic check_outputs();
    check_eq("mem_ld", mem_req_ld, exp_ld);
    check_eq("mem_st", mem_req_st, exp_st);
    if (exp_ld || exp_st) begin
      check_eq("mem_addr", mem_req_addr, exp_addr);
      check_eq("mem_data", mem_req_d_or_tag, exp_data);
    end
    check_eq("pe_stall", pe_req_stall, exp_stall);
    check_eq("rsp_push", pe_rsp_push, exp_rsp_push);
    check_eq("rsp_tag", pe_rsp_tag, exp_rsp_tag);
    check_eq("rsp_q", pe_rsp_q, exp_rsp_q);
    check_eq("mem_rsp_stall", mem_rsp_stall, exp_mrs);
    check_eq("err_q", dut.err_q, exp_err);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clr_all();
    pe_req_ld = '0; pe_req_st = '0; pe_req_addr = '0; pe_req_d_or_tag = '0;
    pe_rsp_stall = '0; mem_req_stall = 0; mem_rsp_push = 0; mem_rsp_tag = '0; mem_rsp_q = '0;
  endtask

  task automatic set_req(input int pe, input bit ld, input bit st, input logic [47:0] a,
                         input logic [63:0] d);
    pe_req_ld[pe] = ld;
    pe_req_st[pe] = st;
    pe_req_addr[48*pe +: 48] = a;
    pe_req_d_or_tag[64*pe +: 64] = d;
  endtask

  task automatic rand_drive();
    bit st;
    for (int i = 0; i < NP; i++) begin
      st = bit'($urandom_range(0, 1));
      if (m_q[i].size() < THR && $urandom_range(0, 1) == 1)
        set_req(i, !st, st, {16'($urandom), $urandom}, {4'(i), 28'($urandom), $urandom});
      else
        set_req(i, 0, 0, '0, '0);
    end
    mem_req_stall = ($urandom_range(0, 3) == 0);
    mem_rsp_push = bit'($urandom_range(0, 1));
    mem_rsp_tag = 5'($urandom);
    mem_rsp_q = {$urandom, $urandom};
    pe_rsp_stall = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (m_q[0].size() + m_q[1].size() + m_q[2].size() + m_q[3].size() > 0) tick();
    end
    tick();
  endtask

  initial begin
    int cnt[NP];
    int prev;
    int owner;
    int seen;
    clr_all();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_outputs();

    // Single PE load and its response.
    set_req(1, 1, 0, 48'h1000, 64'h5);
    tick();
    check_eq("lat_not_yet", mem_req_ld, 1'b0);
    clr_all();
    tick();
    check_eq("ld1_valid", mem_req_ld, 1'b1);
    check_eq("ld1_addr", mem_req_addr, 48'h1000);
    check_eq("ld1_tag", mem_req_d_or_tag[4:0], 5'b01101);
    mem_rsp_push = 1; mem_rsp_tag = 5'b01101; mem_rsp_q = 64'hABCD;
    tick();
    check_eq("rsp1_push", pe_rsp_push, 4'b0010);
    check_eq("rsp1_tag", pe_rsp_tag, 3'd5);
    check_eq("rsp1_q", pe_rsp_q, 64'hABCD);
    clr_all();
    tick();

    // Fairness: every PE keeps its FIFO non-empty.
    for (int i = 0; i < NP; i++) cnt[i] = 0;
    prev = -1;
    for (int c = 0; c < 24; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (m_q[i].size() < THR) set_req(i, 0, 1, 48'(c * 64 + i), {4'(i), 28'(c), $urandom});
        else set_req(i, 0, 0, '0, '0);
      end
      tick();
      if (c >= 4) begin
        check_eq("fair_st", mem_req_st, 1'b1);
        owner = int'(mem_req_d_or_tag[63:60]);
        if (owner < NP) cnt[owner]++;
        if (prev >= 0) check_eq("rr_rot", owner, (prev + 1) % NP);
        prev = owner;
      end
    end
    for (int i = 0; i < NP; i++) check_eq("fair_cnt", cnt[i], 5);
    clr_all();
    drain();

    // Memory stall with PE0 streaming 8 loads into its skid space.
    mem_req_stall = 1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_req(0, 1, 0, 48'(i * 16), 64'(i));
      else set_req(0, 0, 0, '0, '0);
      tick();
      if (i == 3) check_eq("stall_lo", pe_req_stall[0], 1'b0);
      if (i == 4) check_eq("stall_hi", pe_req_stall[0], 1'b1);
    end
    clr_all();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_req_ld) begin
        check_eq("stall_order", mem_req_d_or_tag[4:0], 5'(seen));
        seen++;
      end
    end
    check_eq("stall_seen", seen, 8);

    // FIFO3 full, granted and written in the same cycle.
    mem_req_stall = 1;
    for (int i = 0; i < 8; i++) begin
      set_req(3, 1, 0, 48'(32'h300 + i), 64'(i));
      tick();
    end
    mem_req_stall = 0;
    set_req(3, 1, 0, 48'h3FF, 64'h7);
    tick();
    check_eq("full_pop_err", dut.err_q, 1'b0);
    check_eq("full_pop_stall", pe_req_stall[3], 1'b1);
    clr_all();
    drain();

    // Response backpressure.
    pe_rsp_stall = 4'b0100;
    tick();
    check_eq("mrs_set", mem_rsp_stall, 1'b1);
    pe_rsp_stall = '0;
    tick();
    check_eq("mrs_clr", mem_rsp_stall, 1'b0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rand_drive();
      tick();
    end

    // Asynchronous reset between clock edges during traffic.
    rand_drive();
    #2 rst_n = 0;
    #1;
    check_eq("rst_mem", {mem_req_ld, mem_req_st, mem_req_addr, mem_req_d_or_tag}, '0);
    check_eq("rst_pe", {pe_req_stall, pe_rsp_push, pe_rsp_tag, pe_rsp_q, mem_rsp_stall}, '0);
    clr_all();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NP; i++) set_req(i, 1, 0, 48'(i), 64'(i));
    tick();
    clr_all();
    tick();
    check_eq("rst_first_ld", mem_req_ld, 1'b1);
    check_eq("rst_first_pe", mem_req_d_or_tag[4:3], 2'd0);
    drain();
    check_eq("err_final", dut.err_q, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
